// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command bytes
// and default bus timing for a 50 MHz system clock.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE,
    ERROR
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  localparam int DEF_INHIBIT_CYCLES = 5000;    // 100 us
  localparam int DEF_TIMEOUT_CYCLES = 750000;  // 15 ms
  localparam int DEF_SYNC_STAGES    = 2;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Bits shifted out after the start bit, LSB first: data, parity, stop.
  function automatic logic [9:0] build_frame(input logic [7:0] data);
    return {1'b1, odd_parity(data), data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the PS2_CLK/PS2_DATA pin readbacks into the CLK domain and
// flags device clock falling edges. Shared with the PS/2 keyboard receiver.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clk_in,
  input  logic data_in,
  output logic sync_clk,
  output logic sync_data,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  always_comb begin
    // Shift the new sample in at bit 0; the oldest sample falls off the top.
    clk_sync_d  = SYNC_STAGES'({clk_sync_q, clk_in});
    data_sync_d = SYNC_STAGES'({data_sync_q, data_in});
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
  end

  // NOTE: state is updated only with non-blocking assignments in always_ff so
  // every flop samples the values from before the edge, whatever the order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // An idle bus is pulled high, so resetting to 1 avoids a false fall.
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
  assign sync_data = data_sync_q[SYNC_STAGES-1];
  assign clk_fall  = clk_prev_q & ~sync_clk;

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter: request-to-send, shifts one command byte on
// device-generated clocks, checks the device ACK and reports done/error.
module ps2_host_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int TIMER_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic sync_clk, sync_data, clk_fall;

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .CLK      (CLK),
    .RESET    (RESET),
    .clk_in   (PS2_CLK),
    .data_in  (PS2_DATA),
    .sync_clk (sync_clk),
    .sync_data(sync_data),
    .clk_fall (clk_fall)
  );

  tx_state_t          state_q, state_d;
  logic [9:0]         shift_q, shift_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               clk_low_q, clk_low_d;
  logic               data_low_q, data_low_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic timed_out;
  assign timed_out = (timer_q == TIMEOUT_LAST);

  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    timer_d    = timer_q;
    data_low_d = data_low_q;

    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d   = build_frame(tx_data);
          bit_idx_d = 4'd0;
          timer_d   = '0;
          state_d   = INHIBIT;
        end
      end

      // Device falls seen here or in REQ are contention; host inhibit wins.
      INHIBIT: begin
        if (timer_q == INHIBIT_LAST) begin
          timer_d    = '0;
          data_low_d = 1'b1;
          state_d    = REQ;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      REQ: begin
        timer_d = '0;
        state_d = SEND;
      end

      // The start bit stays on the bus until the device's first falling edge.
      SEND: begin
        if (clk_fall) begin
          data_low_d = ~shift_q[bit_idx_q];
          bit_idx_d  = bit_idx_q + 4'd1;
          timer_d    = '0;
          if (bit_idx_q == 4'd9) state_d = ACK;
        end else if (timed_out) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ACK: begin
        if (clk_fall) begin
          timer_d = '0;
          state_d = sync_data ? ERROR : WAIT_IDLE;
        end else if (timed_out) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      WAIT_IDLE: begin
        if (sync_clk && sync_data) begin
          state_d = DONE;
        end else if (clk_fall) begin
          timer_d = '0;
        end else if (timed_out) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // NOTE: outputs are decoded from the next state and registered, so each
    // one changes on the same edge as the state and no input reaches a pin
    // combinationally.
    if (state_d inside {IDLE, INHIBIT, DONE, ERROR}) data_low_d = 1'b0;
    clk_low_d = (state_d == INHIBIT) || (state_d == REQ);
    done_d    = (state_d == DONE);
    error_d   = (state_d == ERROR);
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      timer_q    <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      timer_q    <= timer_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      done_q     <= done_d;
      error_q    <= error_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready           = ready_q;
  assign tx_busy            = busy_q;
  assign tx_done            = done_q;
  assign tx_error           = error_q;
  assign ps2_clk_drive_low  = clk_low_q;
  assign ps2_data_drive_low = data_low_q;

endmodule
